// File: rtl/sensor_serial_mod5.sv
// Serial MSB-first sensor word receiver with on-the-fly mod-5 remainder,
// valid/ready handoff, framing/overrun pulses and a delivered-word counter.
module sensor_serial_mod5 #(
  parameter int unsigned WORD_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 frame_start,
  input  logic                 out_ready,
  output logic [WORD_BITS-1:0] sensor_word,
  output logic [2:0]           rest,
  output logic                 word_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [7:0]           word_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REM_W = 3;
  localparam int unsigned WCNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // r' = (2r + b) mod 5 as a pure lookup
  function automatic logic [REM_W-1:0] rem_step(input logic [REM_W-1:0] r, input logic b);
    logic [REM_W-1:0] nxt;
    case (r)
      3'd0:    nxt = b ? 3'd1 : 3'd0;
      3'd1:    nxt = b ? 3'd3 : 3'd2;
      3'd2:    nxt = b ? 3'd0 : 3'd4;
      3'd3:    nxt = b ? 3'd2 : 3'd1;
      3'd4:    nxt = b ? 3'd4 : 3'd3;
      default: nxt = 3'd0;
    endcase
    return nxt;
  endfunction

  state_e               state_q, state_d;
  logic [REM_W-1:0]     r_q, r_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [REM_W-1:0]     rest_q, rest_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic [WCNT_W-1:0]    count_q, count_d;

  logic [REM_W-1:0]     r_next;
  logic [WORD_BITS-1:0] shifted;

  assign r_next  = rem_step(r_q, bit_in);
  assign shifted = WORD_BITS'({shift_q, bit_in});

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    rest_d  = rest_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        if (bit_valid && frame_start) begin
          r_d     = REM_W'(bit_in);
          shift_d = WORD_BITS'(bit_in);
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid && frame_start) begin
          r_d     = REM_W'(bit_in);
          shift_d = WORD_BITS'(bit_in);
          cnt_d   = CNT_W'(1);
          ferr_d  = 1'b1;
        end else if (bit_valid) begin
          shift_d = shifted;
          r_d     = r_next;
          if (cnt_q == LAST_CNT) begin
            word_d  = shifted;
            rest_d  = r_next;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          count_d = WCNT_W'(count_q + WCNT_W'(1));
          // Handoff and the next word's MSB may share a cycle
          if (bit_valid && frame_start) begin
            r_d     = REM_W'(bit_in);
            shift_d = WORD_BITS'(bit_in);
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (bit_valid) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      rest_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      rest_q  <= rest_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      count_q <= count_d;
    end
  end

  assign sensor_word = word_q;
  assign rest        = rest_q;
  assign word_valid  = valid_q;
  assign frame_err   = ferr_q;
  assign overrun     = ovr_q;
  assign word_count  = count_q;

endmodule
